mixer_iq_dec: RTL

MIXER_IQ_DEC -- requirements
Module: mixer_iq_dec

---
 rtl/mixer_pkg.sv | 13 +
 rtl/rf_sync_chain.sv | 26 ++
 rtl/mixer_iq_dec.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mixer_pkg.sv
// Shared constants and sample types for the mixer/decimator and the NCO that feeds it.
package mixer_pkg;

  localparam int LO_W_DEF        = 8;
  localparam int ACC_W_DEF       = 16;
  localparam int DEC_LOG2_DEF    = 4;
  localparam int SYNC_STAGES_DEF = 2;

  // Signed LO sample as produced by the NCO, and the decimated accumulator word.
  typedef logic signed [LO_W_DEF-1:0]  lo_sample_t;
  typedef logic signed [ACC_W_DEF-1:0] acc_sample_t;

endpackage

// File: rtl/rf_sync_chain.sv
// Multi-flop synchronizer for the asynchronous 1-bit comparator input.
// All flops reset to 1 so the chain idles at the comparator's high level.
module rf_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through STAGES flops; the last one is metastability-clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      // NOTE: non-blocking so every stage samples its neighbour's pre-edge value; blocking would collapse the chain to one flop.
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mixer_iq_dec.sv
// 1-bit RF quadrature mixer with integrate-and-dump decimation.
// The synchronized RF bit selects +LO or -LO for each channel; products are
// summed over groups of 2^DEC_LOG2 samples and dumped as I/Q words.
// Optional build macro: MIXER_IQ_DEC_SAT_EN -- saturate the negation of the
// most negative LO value and pulse ovf; otherwise negation wraps and ovf is 0.
module mixer_iq_dec
  import mixer_pkg::*;
#(
  parameter int LO_W        = LO_W_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int DEC_LOG2    = DEC_LOG2_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    rf_in,
  input  logic signed [LO_W-1:0]  lo_sin,
  input  logic signed [LO_W-1:0]  lo_cos,
  input  logic                    lo_valid,
  output logic                    rf_out,
  output logic signed [LO_W-1:0]  mix_sin,
  output logic signed [LO_W-1:0]  mix_cos,
  output logic                    mix_valid,
  output logic signed [ACC_W-1:0] dump_sin,
  output logic signed [ACC_W-1:0] dump_cos,
  output logic                    dump_valid,
  output logic                    ovf
);

  localparam logic signed [LO_W-1:0] LO_MIN = {1'b1, {(LO_W-1){1'b0}}};
  localparam logic signed [LO_W-1:0] LO_MAX = ~LO_MIN;

  logic rf_sync;

  rf_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_rf_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rf_in),
    .q_o   (rf_sync)
  );

  assign rf_out = rf_sync;

  // ---------------------------------------------------------------- mixer
  logic signed [LO_W-1:0] neg_sin, neg_cos;
  logic signed [LO_W-1:0] mix_sin_d, mix_cos_d;
  logic signed [LO_W-1:0] mix_sin_q, mix_cos_q;
  logic                   mix_valid_q;
  logic                   sat_hit;
  logic                   take_sample;

  assign take_sample = lo_valid & en;

  // Negate each LO channel (saturating the most negative value when enabled) and pick by RF bit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
    neg_sin = -lo_sin;
    neg_cos = -lo_cos;
    sat_hit = 1'b0;
`ifdef MIXER_IQ_DEC_SAT_EN
    if (lo_sin == LO_MIN) begin
      neg_sin = LO_MAX;
      sat_hit = 1'b1;
    end
    if (lo_cos == LO_MIN) begin
      neg_cos = LO_MAX;
      sat_hit = 1'b1;
    end
`endif
    mix_sin_d = rf_sync ? neg_sin : lo_sin;
    mix_cos_d = rf_sync ? neg_cos : lo_cos;
  end

  // Register mixer products; they hold whenever no enabled LO sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_sin_q   <= '0;
      mix_cos_q   <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      mix_valid_q <= take_sample;
      if (take_sample) begin
        mix_sin_q <= mix_sin_d;
        mix_cos_q <= mix_cos_d;
      end
    end
  end

`ifdef MIXER_IQ_DEC_SAT_EN
  logic ovf_q;

  // Flag saturation in the same cycle the saturated product becomes visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= take_sample & rf_sync & sat_hit;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign mix_sin   = mix_sin_q;
  assign mix_cos   = mix_cos_q;
  assign mix_valid = mix_valid_q;

  // ------------------------------------------------------------ decimator
  logic signed [ACC_W-1:0] acc_sin_q, acc_cos_q;
  logic signed [ACC_W-1:0] sum_sin, sum_cos;
  logic signed [ACC_W-1:0] dump_sin_q, dump_cos_q;
  logic                    dump_valid_q;
  logic [DEC_LOG2-1:0]     cnt_q;

  assign sum_sin = acc_sin_q + {{(ACC_W-LO_W){mix_sin_q[LO_W-1]}}, mix_sin_q};
  assign sum_cos = acc_cos_q + {{(ACC_W-LO_W){mix_cos_q[LO_W-1]}}, mix_cos_q};

  // Integrate products over a full group, dump on the last sample; en low flushes the group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sin_q    <= '0;
      acc_cos_q    <= '0;
      dump_sin_q   <= '0;
      dump_cos_q   <= '0;
      dump_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      dump_valid_q <= 1'b0;
      if (!en) begin
        acc_sin_q <= '0;
        acc_cos_q <= '0;
        cnt_q     <= '0;
      end else if (mix_valid_q) begin
        if (cnt_q == '1) begin
          dump_sin_q   <= sum_sin;
          dump_cos_q   <= sum_cos;
          dump_valid_q <= 1'b1;
          acc_sin_q    <= '0;
          acc_cos_q    <= '0;
          cnt_q        <= '0;
        end else begin
          acc_sin_q <= sum_sin;
          acc_cos_q <= sum_cos;
          cnt_q     <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign dump_sin   = dump_sin_q;
  assign dump_cos   = dump_cos_q;
  assign dump_valid = dump_valid_q;

endmodule
